// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit multiplexed seven-segment scanner.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // True when digit k (k>0) and every more significant digit are zero with no decimal point.
  function automatic logic lead_zero(input logic [15:0] v, input logic [3:0] d, input logic [1:0] k);
    logic z;
    z = (k != 2'd0);
    for (int unsigned j = 0; j < 4; j++) begin
      if (j >= 32'(k) && (v[4*j +: 4] != 4'h0 || d[j])) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder (active-low cathodes).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = FONT[nibble];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scanner with inter-digit blanking.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic        in_clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  if (DIV_W < 2 || DIV_W > 24) begin : g_bad_div_w
    $error("seg7_scan_ctrl: DIV_W must be in 2..24");
  end
  if (BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_bad_blank_cyc
    $error("seg7_scan_ctrl: BLANK_CYC must be in 1..255");
  end

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [DIV_W-1:0] show_cnt, show_cnt_nxt;
  logic [7:0]       blank_cnt, blank_cnt_nxt;
  logic [15:0]      snap_val, snap_val_nxt;
  logic [3:0]       snap_dp, snap_dp_nxt;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  logic             blank_done;
  logic [3:0]       nibble;
  logic [6:0]       seg_dec;
  logic             suppress;

  assign blank_done = (state == BLANK) && (blank_cnt == BLANK_LAST);

  // The snapshot and the first SHOW cycle's outputs load on the same edge,
  // so the digit data is taken from the snapshot's next value.
  always_comb begin
    snap_val_nxt = snap_val;
    snap_dp_nxt  = snap_dp;
    if (blank_done && idx == 2'd0) begin
      snap_val_nxt = value;
      snap_dp_nxt  = dp_in;
    end
  end

  assign nibble = snap_val_nxt[{idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign suppress = lead_zero(snap_val_nxt, snap_dp_nxt, idx);
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    show_cnt_nxt  = show_cnt;
    blank_cnt_nxt = blank_cnt;
    an_nxt        = an;
    seg_nxt       = seg;
    dp_nxt        = dp;

    case (state)
      BLANK: begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (blank_done) begin
          state_nxt     = SHOW;
          blank_cnt_nxt = '0;
          show_cnt_nxt  = '0;
          if (digit_en[idx] && !suppress) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = seg_dec;
            dp_nxt  = ~snap_dp_nxt[idx];
          end
        end else begin
          blank_cnt_nxt = blank_cnt + 8'd1;
        end
      end
      SHOW: begin
        show_cnt_nxt = show_cnt + 1'b1;
        if (&show_cnt) begin
          state_nxt    = BLANK;
          idx_nxt      = idx + 2'd1;
          show_cnt_nxt = '0;
          an_nxt       = AN_OFF;
          seg_nxt      = SEG_OFF;
          dp_nxt       = 1'b1;
        end
      end
      default: begin
        state_nxt = BLANK;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state     <= BLANK;
      idx       <= '0;
      show_cnt  <= '0;
      blank_cnt <= '0;
      snap_val  <= '0;
      snap_dp   <= '0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      show_cnt  <= show_cnt_nxt;
      blank_cnt <= blank_cnt_nxt;
      snap_val  <= snap_val_nxt;
      snap_dp   <= snap_dp_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp        <= dp_nxt;
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIV_W, default 16: SHOW-slot length is 2^DIV_W clocks; legal range 2..24.
REQ-002 Parameter BLANK_CYC, default 4: inter-digit blanking length in clocks; legal range 1..255.
REQ-003 Port in_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port value, input, 16: four hex digits; digit k is value[4k+3:4k].
REQ-006 Port dp_in, input, 4: decimal point request per digit, active-high.
REQ-007 Port digit_en, input, 4: per-digit display enable, active-high.
REQ-008 Port an, output, 4: anode selects, active-low, at most one low at any time.
REQ-009 Port seg, output, 7: cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 Port dp, output, 1: decimal-point cathode, active-low.

Function
REQ-011 FSM states: BLANK and SHOW; 2-bit digit index idx cycles 0,1,2,3,0.
REQ-012 BLANK: all outputs off (an=4'hF, seg=7'h7F, dp=1) for exactly BLANK_CYC clocks, then enter SHOW.
REQ-013 SHOW: lasts exactly 2^DIV_W clocks, measured by a DIV_W-bit counter cleared on SHOW entry; at terminal count (all ones), enter BLANK and set idx to idx+1 mod 4.
REQ-014 Frame period is 4*(2^DIV_W+BLANK_CYC) clocks; the counter wraps with no lost or extra cycles.
REQ-015 Outputs are registered and change on the same edge as the state transition: the first SHOW cycle already drives the digit.
REQ-016 In SHOW with digit_en[idx]=1, drive an[idx]=0 with all other anodes high, seg=decode(snapshot nibble idx), and dp=~snapshot dp bit idx.
REQ-017 In SHOW with digit_en[idx]=0, outputs stay off; slot timing is unchanged.
REQ-018 On every BLANK->SHOW transition with idx=0, snapshot value and dp_in; digits 1..3 of that frame use the snapshot (no tearing).
REQ-019 Decode is the standard hex font: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-020 Input changes outside the snapshot edge have no effect on outputs until the next frame; changes to digit_en take effect at the next SHOW entry.

Reset
REQ-021 While reset=1: state=BLANK, idx=0, counters=0, snapshot=0, an=4'hF, seg=7'h7F, dp=1.
REQ-022 Reset asserted mid-SHOW or mid-BLANK forces the REQ-021 state on the next edge; after release, operation restarts with a full BLANK_CYC blanking, then digit 0.

Configuration
REQ-023 Macro SEG7_LEADING_ZERO_BLANK_EN: when defined, digit k (k=3..1) is suppressed (an high, seg=7'h7F, dp=1) if snapshot nibbles k..3 are all zero and snapshot dp bits k..3 are all zero; digit 0 is never suppressed.
REQ-024 When SEG7_LEADING_ZERO_BLANK_EN is undefined, all enabled digits display, including leading zeros; timing is identical in both builds.

Structure
REQ-025 Package seg7_pkg holds the state enum (BLANK, SHOW), the 16-entry font constant table, and the off constants SEG_OFF=7'h7F and AN_OFF=4'hF.
REQ-026 Combinational sub-module seg7_decode (4-bit nibble in, 7-bit seg out) implements REQ-019; seg7_scan_ctrl instantiates it once.

Verification (bench uses DIV_W=4, BLANK_CYC=2)
REQ-027 Reset, value=16'h1234, dp_in=0, digit_en=4'hF -> 2 clocks off, then 16 clocks of an=4'hE/seg=7'h19, 2 clocks off, then 16 clocks of an=4'hD/seg=7'h30, then 2, then 1; the pattern repeats every 72 clocks.
REQ-028 value changes 16'h1234->16'hABCD during the digit-2 slot -> digits 2 and 3 still show 2 and 1; the next frame shows digit 0 as 7'h21.
REQ-029 digit_en=4'b0101 -> an is never 4'hD or 4'h7; digits 0 and 2 keep their exact slot timing.
REQ-030 reset pulsed for 1 clock in the middle of the digit-2 SHOW -> next edge an=4'hF, seg=7'h7F; 2 clocks later digit 0 shows.
REQ-031 Macro defined, value=16'h0050 -> digits 3 and 2 stay off, digit 1 shows 7'h12, digit 0 shows 7'h40; value=0 -> only digit 0 lit (7'h40).
REQ-032 Throughout all runs, assert that an never has more than one bit low and that all outputs are off in every BLANK cycle.
